register_file_sb: RTL and testbench
===================================

# register_file_sb

Parametrised successor to the CPU's 32×32 register bank. It provides two combinational read ports and one write port, with register 0 hardwired to zero. It adds a per-register scoreboard (busy bits) so the decode stage can detect pending writes. A reset-triggered sequential clear engine zeroes the storage one entry per cycle, so no multi-driver reset loop is needed. It sits between decode (reads, issue) and write-back (writes).

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width in bits.
- `ADDR_WIDTH`, 5, address width; depth `DEPTH = 1<<ADDR_WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `write`  in  1  write-back enable.
- `addr_in`  in  ADDR_WIDTH  write address.
- `data_in`  in  DATA_WIDTH  write data.
- `addr_out1`, `addr_out2`  in  ADDR_WIDTH  read addresses.
- `data_out1`, `data_out2`  out  DATA_WIDTH  read data (combinational).
- `busy_out1`, `busy_out2`  out  1  scoreboard bit for each read address (combinational).
- `issue`  in  1  decode issued an instruction that will write `issue_addr`.
- `issue_addr`  in  ADDR_WIDTH  destination of the issued instruction.
- `ready`  out  1  clear engine finished; the block accepts writes and issues.

## Operation
- State machine, 2 states:
  - CLEAR: entered on any cycle with `reset`=1. The counter `clr_cnt` is set to 0 and all busy bits are cleared in that same edge.
    - Each later cycle in CLEAR writes 0 to `bank[clr_cnt]`, then `clr_cnt++`.
    - When `clr_cnt` = DEPTH-1 is written, the next state is READY.
    - `clr_cnt` is ADDR_WIDTH+1 bits wide, so the last index does not wrap.
  - READY: normal operation; stays here until `reset`.
- Reset is asserted on a CLEAR or READY cycle. Reset mid-clear restarts from index 0. Outputs while `reset`=1 follow the CLEAR rules.
- In CLEAR:
  - `ready`=0.
  - `write` and `issue` are ignored.
  - `data_out1/2` = 0 and `busy_out1/2` = 0 regardless of address.
- Write (READY): if `write`=1 and `addr_in`≠0, then `bank[addr_in] <= data_in` and `busy[addr_in] <= 0`.
- Issue (READY): if `issue`=1 and `issue_addr`≠0, then `busy[issue_addr] <= 1`.
- Same-cycle `write` and `issue` to the same nonzero address: the data is written, busy ends at 1 (the new producer wins).
- Register 0:
  - Reads return 0.
  - Busy bit is constant 0.
  - Writes and issues to it are dropped.
- Reads:
  - `data_outN = bank[addr_outN]`, or the bypass value (see Configuration).
  - `busy_outN = busy[addr_outN]`.
- Both read ports may address the same register. Both ports then return identical values.

## Timing
- Read latency: 0 cycles (combinational from addresses and state).
- Write and issue take effect at the rising edge where they are sampled. They are visible to reads from the next cycle on (without bypass).
- `busy` set by `issue` at edge N: `busy_out` is 1 from cycle N+1.
- `busy` cleared by `write` at edge N: `busy_out` is 0 from cycle N+1.
- Clear duration: `reset` high at edge R, low afterwards. The entries are written at edges R+1 … R+DEPTH. `ready`=1 from the cycle after edge R+DEPTH, which is DEPTH cycles after reset deasserts.
- Output values:
  - `ready`: 0 after reset.
  - `data_out*`, `busy_out*`: 0 until `ready`.
  - Storage: all 0 once `ready` rises.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - When `write`=1, `addr_in`≠0 and `addr_in`==`addr_outN` in READY, `data_outN = data_in` in the same cycle.
  - `busy_outN` = 0 in that case unless an `issue` to the same address is also present that cycle.
- Not defined:
  - Reads return pre-write storage in the write cycle.
  - Busy reflects registered state only.
  - Decode must stall one extra cycle.

## Test plan
- Reset 1 cycle then release, DEPTH=32 → `ready`=0 for 32 cycles, 1 on the 33rd. Reading all addresses afterwards gives 0.
- In READY, write 0xDEADBEEF to r5, then read r5 on both ports the next cycle → 0xDEADBEEF on both. Write 0x1234 to r0 → r0 reads 0.
- Issue r7 → `busy_out1`=1 the next cycle with `addr_out1`=7. Write r7=0x55 → busy 0 the next cycle and data 0x55. Issue and write r7 in the same cycle → busy stays 1 and data is updated.
- With `REGFILE_BYPASS_EN`: write r3=0xA5A5A5A5 while `addr_out2`=3 → `data_out2`=0xA5A5A5A5 in the same cycle. Without the macro → old value, new value the next cycle.
- Assert `reset` at clear index 10 → counter restarts. `ready` rises exactly 32 cycles after the second reset deasserts, and pre-reset register contents read 0.
- `write`/`issue` during CLEAR to r4 with 0xFF → ignored: after `ready`, r4 reads 0 and busy is 0.

Source files
------------

// File: rtl/register_file_sb.sv
// Register bank with per-register busy scoreboard and a sequential clear engine.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module register_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_out1,
  input  logic [ADDR_WIDTH-1:0] addr_out2,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic                  busy_out1,
  output logic                  busy_out2,
  input  logic                  issue,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LastIdx = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CntOne  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH:0]     clrCnt_q;
  logic [DEPTH-1:0]        busy_q;
  logic [DATA_WIDTH-1:0]   bank_q [DEPTH];

  logic active;
  logic writeOk;
  logic issueOk;

  // A cycle with reset high behaves like CLEAR even before the state register catches up.
  assign active  = (state_q == READY) && !reset;
  assign writeOk = active && write && (addr_in != '0);
  assign issueOk = active && issue && (issue_addr != '0);
  assign ready   = active;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLEAR;
      clrCnt_q <= '0;
      busy_q   <= '0;
    end else if (state_q == CLEAR) begin
      bank_q[clrCnt_q[ADDR_WIDTH-1:0]] <= '0;
      clrCnt_q <= clrCnt_q + CntOne;
      if (clrCnt_q == LastIdx) begin
        state_q <= READY;
      end
    end else begin
      if (writeOk) begin
        bank_q[addr_in] <= data_in;
        busy_q[addr_in] <= 1'b0;
      end
      // Issue is applied after write so a same-cycle new producer keeps the register busy.
      if (issueOk) begin
        busy_q[issue_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    data_out1 = '0;
    data_out2 = '0;
    busy_out1 = 1'b0;
    busy_out2 = 1'b0;
    if (active) begin
      if (addr_out1 != '0) begin
        data_out1 = bank_q[addr_out1];
        busy_out1 = busy_q[addr_out1];
      end
      if (addr_out2 != '0) begin
        data_out2 = bank_q[addr_out2];
        busy_out2 = busy_q[addr_out2];
      end
`ifdef REGFILE_BYPASS_EN
      if (writeOk && (addr_in == addr_out1)) begin
        data_out1 = data_in;
        busy_out1 = issueOk && (issue_addr == addr_in);
      end
      if (writeOk && (addr_in == addr_out2)) begin
        data_out2 = data_in;
        busy_out2 = issueOk && (issue_addr == addr_in);
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb (default 32x32 configuration).
module tb_register_file_sb;

  logic        clk;
  logic        reset;
  logic        write;
  logic [4:0]  addr_in;
  logic [31:0] data_in;
  logic [4:0]  addr_out1;
  logic [4:0]  addr_out2;
  logic [31:0] data_out1;
  logic [31:0] data_out2;
  logic        busy_out1;
  logic        busy_out2;
  logic        issue;
  logic [4:0]  issue_addr;
  logic        ready;

  int vectorCount = 0;
  int missCount   = 0;

  register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .addr_out1 (addr_out1),
    .addr_out2 (addr_out2),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .busy_out1 (busy_out1),
    .busy_out2 (busy_out2),
    .issue     (issue),
    .issue_addr(issue_addr),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Counts cycles with ready low, starting from the current (negedge) cycle, bounded.
  task automatic measureClear(output int cycles);
    cycles = 0;
    while (!ready && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic is, input logic [4:0] ia);
    write = w; addr_in = wa; data_in = wd; issue = is; issue_addr = ia;
    @(negedge clk);
    write = 1'b0; issue = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [31:0] orAcc;
    reset = 1'b1; write = 1'b0; addr_in = '0; data_in = '0;
    addr_out1 = 5'd5; addr_out2 = 5'd0; issue = 1'b0; issue_addr = '0;

    @(negedge clk);
    #1;
    checkOutput("resetReady", {31'd0, ready}, 32'd0);
    checkOutput("resetData1", data_out1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    measureClear(cyc);
    checkOutput("clearCycles", cyc, 32'd32);
    checkOutput("readyHigh", {31'd0, ready}, 32'd1);

    orAcc = '0;
    for (int i = 0; i < 32; i++) begin
      addr_out1 = 5'(i); addr_out2 = 5'(31 - i);
      #1;
      orAcc = orAcc | data_out1 | data_out2 | {30'd0, busy_out1, busy_out2};
    end
    checkOutput("allZeroAfterClear", orAcc, 32'd0);

    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    addr_out1 = 5'd5; addr_out2 = 5'd5;
    #1;
    checkOutput("r5Port1", data_out1, 32'hDEADBEEF);
    checkOutput("r5Port2", data_out2, 32'hDEADBEEF);

    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
    addr_out1 = 5'd0;
    #1;
    checkOutput("r0Data", data_out1, 32'd0);
    checkOutput("r0Busy", {31'd0, busy_out1}, 32'd0);

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    addr_out1 = 5'd7; addr_out2 = 5'd5;
    #1;
    checkOutput("issueBusy7", {31'd0, busy_out1}, 32'd1);
    checkOutput("notBusy5", {31'd0, busy_out2}, 32'd0);

    applyStimulus(1'b1, 5'd7, 32'h55, 1'b0, 5'd0);
    #1;
    checkOutput("writeClearsBusy7", {31'd0, busy_out1}, 32'd0);
    checkOutput("r7Data55", data_out1, 32'h55);

    applyStimulus(1'b1, 5'd7, 32'h66, 1'b1, 5'd7);
    #1;
    checkOutput("issueWinsBusy7", {31'd0, busy_out1}, 32'd1);
    checkOutput("r7Data66", data_out1, 32'h66);

    write = 1'b1; addr_in = 5'd3; data_in = 32'hA5A5A5A5; addr_out2 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypassSameCycle", data_out2, 32'hA5A5A5A5);
`else
    checkOutput("noBypassSameCycle", data_out2, 32'd0);
`endif
    @(negedge clk);
    write = 1'b0;
    #1;
    checkOutput("r3NextCycle", data_out2, 32'hA5A5A5A5);

    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    addr_out1 = 5'd9; addr_out2 = 5'd5;
    reset = 1'b1;
    #1;
    checkOutput("resetGatesData", data_out2, 32'd0);
    checkOutput("resetGatesReady", {31'd0, ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("clearGatesData", data_out1, 32'd0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    checkOutput("midClearNotReady", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    write = 1'b1; addr_in = 5'd4; data_in = 32'hFF; issue = 1'b1; issue_addr = 5'd4;
    measureClear(cyc);
    write = 1'b0; issue = 1'b0;
    checkOutput("restartClearCycles", cyc, 32'd32);

    addr_out1 = 5'd4; addr_out2 = 5'd9;
    #1;
    checkOutput("r4IgnoredData", data_out1, 32'd0);
    checkOutput("r4IgnoredBusy", {31'd0, busy_out1}, 32'd0);
    checkOutput("r9Cleared", data_out2, 32'd0);
    addr_out1 = 5'd5; addr_out2 = 5'd7;
    #1;
    checkOutput("r5Cleared", data_out1, 32'd0);
    checkOutput("r7BusyCleared", {31'd0, busy_out2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
